// File: rtl/task_fifo_bank.sv
// task_fifo_bank
//   Per-level task FIFO bank upstream of the RPU task distributor. One request stream
//   (push/pop scheduling requests) is routed by tree id to a level FIFO; each level FIFO
//   offers a pop/empty/data handshake with data registered one cycle after the pop.
//
// Build option:
//   TASK_FIFO_GUARD_EN  when defined, per-tree occupancy counters drop pops aimed at empty
//                       trees and pushes aimed at full trees (reported on o_drop).
//                       When undefined, every accepted request is written and o_drop is 0.
//
// Ports:
//   i_clk, i_arst_n        clock, asynchronous active-low reset
//   i_task_valid           request valid
//   o_task_ready           target level FIFO not full (combinational)
//   i_task_type            1 = push, 0 = pop
//   i_task_treeId          target tree; level = treeId mod LEVEL
//   i_task_data            push payload (ignored for pops)
//   i_pop_TaskFIFO         per-level dequeue strobe from the distributor
//   o_TaskFIFO_data        per-level registered head entry {type, treeId, data}
//   o_TaskFIFO_empty       per-level empty flag
//   o_drop, o_drop_treeId  one-cycle pulse and tree id of a request discarded by the guard
module task_fifo_bank #(
  parameter int unsigned PTW           = 16,
  parameter int unsigned LEVEL         = 4,
  parameter int unsigned LEVEL_BITS    = $clog2(LEVEL),
  parameter int unsigned TREE_NUM      = 4,
  parameter int unsigned TREE_NUM_BITS = $clog2(TREE_NUM),
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned TREE_CAP      = 64
) (
  input  logic                                    i_clk,
  input  logic                                    i_arst_n,
  input  logic                                    i_task_valid,
  output logic                                    o_task_ready,
  input  logic                                    i_task_type,
  input  logic [TREE_NUM_BITS-1:0]                i_task_treeId,
  input  logic [PTW-1:0]                          i_task_data,
  input  logic [LEVEL-1:0]                        i_pop_TaskFIFO,
  output logic [LEVEL-1:0][PTW+TREE_NUM_BITS:0]   o_TaskFIFO_data,
  output logic [LEVEL-1:0]                        o_TaskFIFO_empty,
  output logic                                    o_drop,
  output logic [TREE_NUM_BITS-1:0]                o_drop_treeId
);

  localparam int unsigned ENTRY_W = PTW + TREE_NUM_BITS + 1;
  localparam int unsigned IDX_W   = $clog2(DEPTH);
  localparam int unsigned PTR_W   = IDX_W + 1;

  // Elaboration-time parameter sanity checks.
  if (TREE_NUM < LEVEL) begin : gBadTreeNum
    $error("TREE_NUM must be >= LEVEL");
  end
  if (TREE_CAP < 1) begin : gBadTreeCap
    $error("TREE_CAP must be >= 1");
  end
  if (DEPTH < 2) begin : gBadDepth
    $error("DEPTH must be >= 2");
  end

  logic [LEVEL_BITS-1:0] tgtLevel;
  logic [LEVEL-1:0]      fullLevel;
  logic                  accept;
  logic                  guardPass;
  logic                  doWrite;
  logic [ENTRY_W-1:0]    wrEntry;

  assign tgtLevel     = i_task_treeId[LEVEL_BITS-1:0];
  // Ready reflects FIFO space only; guard drops still consume the request.
  assign o_task_ready = ~fullLevel[tgtLevel];
  assign accept       = i_task_valid & o_task_ready;
  assign doWrite      = accept & guardPass;
  assign wrEntry      = {i_task_type, i_task_treeId, (i_task_type ? i_task_data : {PTW{1'b0}})};

`ifdef TASK_FIFO_GUARD_EN
  localparam int unsigned CNT_W = $clog2(TREE_CAP + 1);

  logic [TREE_NUM-1:0][CNT_W-1:0] treeCntQ;
  logic [CNT_W-1:0]               curCnt;
  logic                           dropQ;
  logic [TREE_NUM_BITS-1:0]       dropTreeQ;

  assign curCnt    = treeCntQ[i_task_treeId];
  assign guardPass = i_task_type ? (curCnt != CNT_W'(TREE_CAP)) : (curCnt != '0);

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      treeCntQ  <= '0;
      dropQ     <= 1'b0;
      dropTreeQ <= '0;
    end else begin
      dropQ <= accept & ~guardPass;
      if (accept) begin
        if (!guardPass) begin
          dropTreeQ <= i_task_treeId;
        end else if (i_task_type) begin
          treeCntQ[i_task_treeId] <= curCnt + CNT_W'(1);
        end else begin
          treeCntQ[i_task_treeId] <= curCnt - CNT_W'(1);
        end
      end
    end
  end

  assign o_drop        = dropQ;
  assign o_drop_treeId = dropTreeQ;
`else
  assign guardPass     = 1'b1;
  assign o_drop        = 1'b0;
  assign o_drop_treeId = '0;
`endif

  for (genvar l = 0; l < LEVEL; l++) begin : gLevel
    logic [PTR_W-1:0]   wrPtrQ;
    logic [PTR_W-1:0]   rdPtrQ;
    logic [ENTRY_W-1:0] memQ [DEPTH];
    logic [ENTRY_W-1:0] dataQ;
    logic               emptyL;
    logic               wrEn;
    logic               rdEn;

    assign emptyL       = (wrPtrQ == rdPtrQ);
    assign fullLevel[l] = (wrPtrQ[IDX_W-1:0] == rdPtrQ[IDX_W-1:0]) &&
                          (wrPtrQ[IDX_W] != rdPtrQ[IDX_W]);
    assign wrEn         = doWrite && (tgtLevel == LEVEL_BITS'(l));
    // A pop against the registered empty flag is ignored, even if a write lands this cycle.
    assign rdEn         = i_pop_TaskFIFO[l] && !emptyL;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
        wrPtrQ <= '0;
        rdPtrQ <= '0;
        dataQ  <= '0;
      end else begin
        if (wrEn) begin
          wrPtrQ <= wrPtrQ + PTR_W'(1);
        end
        if (rdEn) begin
          rdPtrQ <= rdPtrQ + PTR_W'(1);
          dataQ  <= memQ[rdPtrQ[IDX_W-1:0]];
        end
      end
    end

    // Storage carries no reset so it can map onto RAM; pointers define validity.
    always_ff @(posedge i_clk) begin
      if (wrEn) begin
        memQ[wrPtrQ[IDX_W-1:0]] <= wrEntry;
      end
    end

    assign o_TaskFIFO_empty[l] = emptyL;
    assign o_TaskFIFO_data[l]  = dataQ;
  end

endmodule

// File: tb/tb_task_fifo_bank.sv
module tb_task_fifo_bank;

`ifdef TASK_FIFO_GUARD_EN
  localparam int GUARD = 1;
`else
  localparam int GUARD = 0;
`endif

  // Drive outcomes for a request.
  localparam int OWRITE = 0;
  localparam int ODROP  = 1;
  localparam int OBUSY  = 2;
  localparam int ONONE  = 3;

  logic             clk;
  logic             rstN;
  logic             iValid;
  logic             oReady;
  logic             iType;
  logic [1:0]       iTree;
  logic [15:0]      iData;
  logic [3:0]       iPop;
  logic [3:0][18:0] oData;
  logic [3:0]       oEmpty;
  logic             oDrop;
  logic [1:0]       oDropTree;

  int nChecks = 0;
  int nPassed = 0;

  int          lvlQ[$];
  logic [18:0] entQ[$];
  logic [1:0]  dropQ[$];
  logic [3:0]  pend;

  task_fifo_bank dut (
    .i_clk            (clk),
    .i_arst_n         (rstN),
    .i_task_valid     (iValid),
    .o_task_ready     (oReady),
    .i_task_type      (iType),
    .i_task_treeId    (iTree),
    .i_task_data      (iData),
    .i_pop_TaskFIFO   (iPop),
    .o_TaskFIFO_data  (oData),
    .o_TaskFIFO_empty (oEmpty),
    .o_drop           (oDrop),
    .o_drop_treeId    (oDropTree)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nChecks++;
    if (ok) nPassed++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: compares registered data one cycle after a pop fires and checks drop pulses.
  initial begin
    pend = '0;
    forever begin
      @(negedge clk);
      if (!rstN) begin
        pend = '0;
      end else begin
        for (int l = 0; l < 4; l++) begin
          if (pend[l]) begin
            int idx;
            idx = -1;
            for (int i = 0; i < lvlQ.size(); i++) begin
              if (lvlQ[i] == l) begin
                idx = i;
                break;
              end
            end
            if (idx < 0) begin
              chk(1'b0, "unexpected_pop_data", 32'(oData[l]), 32'hFFFFFFFF);
            end else begin
              chk(oData[l] == entQ[idx], "pop_data", 32'(oData[l]), 32'(entQ[idx]));
              lvlQ.delete(idx);
              entQ.delete(idx);
            end
          end
        end
        if (oDrop) begin
          if (dropQ.size() == 0) begin
            chk(1'b0, "unexpected_drop", 32'(oDropTree), 32'hFFFFFFFF);
          end else begin
            logic [1:0] e;
            e = dropQ.pop_front();
            chk(oDropTree == e, "drop_treeId", 32'(oDropTree), 32'(e));
          end
        end
        pend = iPop & ~oEmpty;
      end
    end
  end

  // Called at posedge+1; commits one cycle and returns at the next posedge+1.
  task automatic drive(input bit v, input bit t, input int tree, input logic [15:0] d,
                       input logic [3:0] pop, input int outc);
    logic [18:0] ent;
    logic [1:0]  tr;
    tr     = tree[1:0];
    iValid = v;
    iType  = t;
    iTree  = tr;
    iData  = d;
    iPop   = pop;
    ent    = {t, tr, (t ? d : 16'h0)};
    #1;
    if (v) chk(oReady == (outc != OBUSY), "task_ready", 32'(oReady), 32'(outc != OBUSY));
    if (v && outc == OWRITE) begin
      lvlQ.push_back(int'(tr));
      entQ.push_back(ent);
    end
    if (v && outc == ODROP) dropQ.push_back(tr);
    @(posedge clk);
    #1;
    iValid = 1'b0;
    iPop   = '0;
  endtask

  task automatic drainAll(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 16'h0, 4'hF, ONONE);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rstN   = 1'b0;
    iValid = 1'b0;
    iType  = 1'b0;
    iTree  = '0;
    iData  = '0;
    iPop   = '0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    chk(oEmpty == 4'hF, "reset_empty", 32'(oEmpty), 32'hF);
    for (int l = 0; l < 4; l++) chk(oData[l] == '0, "reset_data", 32'(oData[l]), 32'h0);
    chk(oDrop == 1'b0, "reset_drop", 32'(oDrop), 32'h0);
    chk(oDropTree == 2'd0, "reset_drop_treeId", 32'(oDropTree), 32'h0);
    rstN = 1'b1;
    @(posedge clk);
    #1;
    chk(oReady == 1'b1, "ready_after_reset", 32'(oReady), 32'h1);

    // Push tree 1, then pop level 1
    drive(1'b1, 1'b1, 1, 16'h00AA, 4'h0, OWRITE);
    chk(oEmpty == 4'b1101, "empty_after_push", 32'(oEmpty), 32'hD);
    drive(1'b0, 1'b0, 0, 16'h0, 4'b0010, ONONE);
    chk(oEmpty == 4'hF, "empty_after_pop", 32'(oEmpty), 32'hF);
    chk(oData[1] == {1'b1, 2'd1, 16'h00AA}, "data_level1", 32'(oData[1]), 32'h500AA);

    // Pop request to an empty tree
    drive(1'b1, 1'b0, 2, 16'h1234, 4'h0, (GUARD != 0) ? ODROP : OWRITE);
    chk(oEmpty == ((GUARD != 0) ? 4'hF : 4'b1011), "empty_after_pop_req", 32'(oEmpty),
        32'((GUARD != 0) ? 4'hF : 4'b1011));
    drive(1'b0, 1'b0, 0, 16'h0, 4'b0100, ONONE);
    chk(oEmpty == 4'hF, "empty_after_drain2", 32'(oEmpty), 32'hF);

    // Fill level 3, ready drops for tree 3 only
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 3, 16'h3000 + 16'(i), 4'h0, OWRITE);
    drive(1'b1, 1'b1, 3, 16'h30FF, 4'h0, OBUSY);
    drive(1'b1, 1'b1, 0, 16'h0101, 4'h0, OWRITE);
    drive(1'b0, 1'b0, 0, 16'h0, 4'b1000, ONONE);
    drive(1'b1, 1'b1, 3, 16'h3009, 4'h0, OWRITE);
    drive(1'b1, 1'b1, 3, 16'h30FE, 4'h0, OBUSY);
    drainAll(9);
    chk(oEmpty == 4'hF, "empty_after_level3", 32'(oEmpty), 32'hF);

    // Tree 0 capacity: zero the count, then TREE_CAP pushes while draining level 0
    drive(1'b1, 1'b0, 0, 16'h0, 4'h0, OWRITE);
    for (int i = 0; i < 64; i++) drive(1'b1, 1'b1, 0, 16'h4000 + 16'(i), 4'b0001, OWRITE);
    drive(1'b1, 1'b1, 0, 16'h4040, 4'b0001, (GUARD != 0) ? ODROP : OWRITE);
    drive(1'b1, 1'b0, 0, 16'h0, 4'b0001, OWRITE);
    drive(1'b1, 1'b1, 0, 16'h4041, 4'b0001, OWRITE);
    drainAll(3);
    chk(oEmpty == 4'hF, "empty_after_cap", 32'(oEmpty), 32'hF);

    // Level 2 full with simultaneous write/pop, then wrap
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 2, 16'h5000 + 16'(i), 4'h0, OWRITE);
    drive(1'b1, 1'b1, 2, 16'h50FF, 4'b0100, OBUSY);
    for (int i = 8; i < 13; i++) drive(1'b1, 1'b1, 2, 16'h5000 + 16'(i), 4'b0100, OWRITE);
    drive(1'b1, 1'b1, 2, 16'h500D, 4'h0, OWRITE);
    drive(1'b1, 1'b1, 2, 16'h50FE, 4'h0, OBUSY);
    drainAll(9);
    chk(oEmpty == 4'hF, "empty_after_wrap", 32'(oEmpty), 32'hF);

    // Asynchronous reset with three entries queued
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1, 16'h6000 + 16'(i), 4'h0, OWRITE);
    drive(1'b0, 1'b0, 0, 16'h0, 4'b0010, ONONE);
    rstN = 1'b0;
    #1;
    chk(oEmpty == 4'hF, "async_reset_empty", 32'(oEmpty), 32'hF);
    for (int l = 0; l < 4; l++) chk(oData[l] == '0, "async_reset_data", 32'(oData[l]), 32'h0);
    // Anything still queued is lost by design.
    lvlQ.delete();
    entQ.delete();
    @(posedge clk);
    #1;
    rstN = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 1, 16'h0, 4'h0, (GUARD != 0) ? ODROP : OWRITE);
    drainAll(2);
    chk(oEmpty == 4'hF, "empty_final", 32'(oEmpty), 32'hF);

    repeat (3) @(posedge clk);
    #1;
    chk(lvlQ.size() == 0, "pending_data", 32'(lvlQ.size()), 32'h0);
    chk(dropQ.size() == 0, "pending_drops", 32'(dropQ.size()), 32'h0);

    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule
